// File: rtl/pipo_bank_ctrl.sv
// pipo_bank_ctrl: in-order bank ownership for a ping-pong producer/consumer channel.
// Define PIPO_STALL_MON_EN to build the stall monitor behind stall_flag/stall_side.
module pipo_bank_ctrl #(
    parameter int BUF_NUM     = 2,
    parameter int IDX_W       = $clog2(BUF_NUM),
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_write,
    input  logic               i_req,
    output logic               i_full_n,
    output logic [IDX_W-1:0]   i_bank,
    input  logic               t_read,
    input  logic               t_req,
    output logic               t_empty_n,
    output logic [IDX_W-1:0]   t_bank,
    output logic [BUF_NUM-1:0] bank_full,
    output logic               proto_err,
    output logic               stall_flag,
    output logic [1:0]         stall_side
);

    localparam int CW = $clog2(BUF_NUM + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BUF_NUM - 1);
    localparam logic [CW-1:0] FULL = CW'(BUF_NUM);

    logic [IDX_W-1:0]   iptr;
    logic [IDX_W-1:0]   tptr;
    logic [CW-1:0]      count;
    logic [BUF_NUM-1:0] full_q;
    logic [BUF_NUM-1:0] full_d;
    logic               perr_q;
    logic               wr_acc;
    logic               rd_acc;

    assign i_full_n  = (count != FULL);
    assign t_empty_n = (count != '0);
    assign i_bank    = iptr;
    assign t_bank    = tptr;
    assign bank_full = full_q;
    assign proto_err = perr_q;

    assign wr_acc = i_write & i_full_n;
    assign rd_acc = t_read & t_empty_n;

    // Next bank-filled vector; the two sides never target the same bank.
    always_comb begin
        full_d = full_q;
        if (rd_acc) full_d[tptr] = 1'b0;
        if (wr_acc) full_d[iptr] = 1'b1;
    end

    // Pointers, occupancy, filled bits and sticky protocol error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            iptr   <= '0;
            tptr   <= '0;
            count  <= '0;
            full_q <= '0;
            perr_q <= 1'b0;
        end else begin
            if (wr_acc) iptr <= (iptr == LAST) ? '0 : iptr + 1'b1;
            if (rd_acc) tptr <= (tptr == LAST) ? '0 : tptr + 1'b1;
            if (wr_acc & ~rd_acc)
                count <= count + 1'b1;
            else if (rd_acc & ~wr_acc)
                count <= count - 1'b1;
            full_q <= full_d;
            if ((i_write & ~i_full_n) | (t_read & ~t_empty_n))
                perr_q <= 1'b1;
        end
    end

`ifdef PIPO_STALL_MON_EN
    typedef enum logic [1:0] {
        MON_IDLE  = 2'd0,
        MON_COUNT = 2'd1,
        MON_STALL = 2'd2
    } mon_t;

    localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(STALL_LIMIT - 1);

    mon_t             mon_q;
    mon_t             mon_d;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       side_q;
    logic             i_blk;
    logic             t_blk;
    logic             blocked;

    assign i_blk   = i_req & ~i_full_n;
    assign t_blk   = t_req & ~t_empty_n;
    assign blocked = i_blk | t_blk;

    // Monitor state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) mon_q <= MON_IDLE;
        else        mon_q <= mon_d;
    end

    // Monitor next state; a limit of one stalls on the first blocked cycle.
    always_comb begin
        mon_d = mon_q;
        unique case (mon_q)
            MON_IDLE: begin
                if (blocked)
                    mon_d = (STALL_LIMIT == 1) ? MON_STALL : MON_COUNT;
            end
            MON_COUNT: begin
                if (!blocked)
                    mon_d = MON_IDLE;
                else if (cnt == LIM_M1)
                    mon_d = MON_STALL;
            end
            MON_STALL: mon_d = MON_STALL;
            default:   mon_d = MON_IDLE;
        endcase
    end

    // Blocked-cycle counter; frozen once stalled so it never wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            unique case (mon_q)
                MON_IDLE:  cnt <= blocked ? CNT_W'(1) : '0;
                MON_COUNT: cnt <= blocked ? cnt + 1'b1 : '0;
                default:   cnt <= cnt;
            endcase
        end
    end

    // Capture which sides were blocked on entry to the stall state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            side_q <= 2'b00;
        else if (mon_q != MON_STALL && mon_d == MON_STALL)
            side_q <= {t_blk, i_blk};
    end

    // Monitor outputs.
    always_comb begin
        stall_flag = (mon_q == MON_STALL);
        stall_side = side_q;
    end
`else
    logic unused_sink;

    assign unused_sink = ^{i_req, t_req, 32'(STALL_LIMIT), 32'(CNT_W)};
    assign stall_flag  = 1'b0;
    assign stall_side  = 2'b00;
`endif

endmodule

// File: tb/tb_pipo_bank_ctrl.sv
// tb_pipo_bank_ctrl: randomized scoreboard bench for pipo_bank_ctrl.
// Reference model is a queue of committed bank indices.
module tb_pipo_bank_ctrl;
    localparam int N   = 2;
    localparam int LIM = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         i_write = 1'b0;
    logic         i_req = 1'b0;
    logic         t_read = 1'b0;
    logic         t_req = 1'b0;
    logic         i_full_n;
    logic         t_empty_n;
    logic [0:0]   i_bank;
    logic [0:0]   t_bank;
    logic [N-1:0] bank_full;
    logic         proto_err;
    logic         stall_flag;
    logic [1:0]   stall_side;

    pipo_bank_ctrl #(
        .BUF_NUM(N), .IDX_W(1), .CNT_W(16), .STALL_LIMIT(LIM)
    ) dut (
        .clock(clock), .reset(reset),
        .i_write(i_write), .i_req(i_req),
        .i_full_n(i_full_n), .i_bank(i_bank),
        .t_read(t_read), .t_req(t_req),
        .t_empty_n(t_empty_n), .t_bank(t_bank),
        .bank_full(bank_full), .proto_err(proto_err),
        .stall_flag(stall_flag), .stall_side(stall_side)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int mq[$];
    int rd_exp[$];
    int wr_exp[$];
    int nwr, nrd, run;
    bit perr_m, stall_m;
    bit [1:0] side_m;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rd_exp.delete();
        wr_exp.delete();
        nwr = 0;
        nrd = 0;
        run = 0;
        perr_m = 0;
        stall_m = 0;
        side_m = 0;
    endtask

    task automatic check_state();
        logic [N-1:0] bf;
        bf = '0;
        foreach (mq[k]) bf[mq[k]] = 1'b1;
        chk("i_full_n", i_full_n, mq.size() != N);
        chk("t_empty_n", t_empty_n, mq.size() != 0);
        chk("i_bank", i_bank, nwr % N);
        chk("t_bank", t_bank, nrd % N);
        chk("bank_full", bank_full, bf);
        chk("proto_err", proto_err, perr_m);
        chk("stall_flag", stall_flag, stall_m);
        chk("stall_side", stall_side, side_m);
    endtask

    task automatic step(input bit w, input bit r);
        bit wa, ra, ib, tb;
        @(negedge clock);
        #1;
        i_write = w;
        t_read  = r;
        wa = w && (mq.size() < N);
        ra = r && (mq.size() > 0);
        ib = i_req && (mq.size() == N);
        tb = t_req && (mq.size() == 0);
        if (wa) wr_exp.push_back(nwr % N);
        if (ra) rd_exp.push_back(mq[0]);
        @(posedge clock);
        if (ra) begin
            void'(mq.pop_front());
            nrd++;
        end
        if (wa) begin
            mq.push_back(nwr % N);
            nwr++;
        end
        if ((w && !wa) || (r && !ra)) perr_m = 1;
`ifdef PIPO_STALL_MON_EN
        if (!stall_m) begin
            if (ib || tb) begin
                run++;
                if (run == LIM) begin
                    stall_m = 1;
                    side_m = {tb, ib};
                end
            end else begin
                run = 0;
            end
        end
`endif
        #1;
        i_write = 1'b0;
        t_read  = 1'b0;
        check_state();
    endtask

    task automatic do_reset();
        @(negedge clock);
        #3;
        reset = 1'b0;
        i_write = 1'b0;
        t_read = 1'b0;
        i_req = 1'b0;
        t_req = 1'b0;
        #1;
        model_reset();
        check_state();
        @(negedge clock);
        #3;
        reset = 1'b1;
    endtask

    // Scoreboard monitor: pops expected banks when a transfer is presented.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (reset && t_read && t_empty_n) begin
                if (rd_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_bank: got %0d expected none", t_bank);
                end else begin
                    chk("rd_bank", t_bank, rd_exp.pop_front());
                end
            end
            if (reset && i_write && i_full_n) begin
                if (wr_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_bank: got %0d expected none", i_bank);
                end else begin
                    chk("wr_bank", i_bank, wr_exp.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #12;
        check_state();
        @(negedge clock);
        #3;
        reset = 1'b1;

        step(1, 0);
        step(1, 0);
        chk("fill_bf", bank_full, 2'b11);
        step(1, 0);
        chk("ovf_err", proto_err, 1);
        step(0, 1);
        chk("drain_tb", t_bank, 1);

        do_reset();
        step(1, 0);
        step(1, 1);
        chk("both_bf", bank_full, 2'b10);

        do_reset();
        step(0, 1);
        chk("udf_err", proto_err, 1);

        do_reset();
        repeat (8) begin
            step(1, 0);
            step(1, 0);
            step(0, 1);
            step(0, 1);
        end
        step(1, 0);
        step(1, 0);
        step(1, 1);
        step(0, 1);
        step(1, 1);

        do_reset();
        repeat (300) begin
            step(($urandom % 2 == 1) && mq.size() < N,
                 ($urandom % 2 == 1) && mq.size() > 0);
        end
        repeat (200) begin
            i_req = ($urandom % 4) == 0;
            t_req = ($urandom % 4) == 0;
            step($urandom % 2 == 1, $urandom % 2 == 1);
        end

        do_reset();
        step(1, 0);
        step(1, 0);
        do_reset();

`ifdef PIPO_STALL_MON_EN
        do_reset();
        step(1, 0);
        step(1, 0);
        i_req = 1'b1;
        repeat (15) step(0, 0);
        chk("stall_15", stall_flag, 0);
        step(0, 0);
        chk("stall_16", stall_flag, 1);
        chk("side_16", stall_side, 2'b01);
        i_req = 1'b0;
        repeat (3) step(0, 0);
        chk("stall_sticky", stall_flag, 1);

        do_reset();
        step(1, 0);
        step(1, 0);
        i_req = 1'b1;
        repeat (15) step(0, 0);
        i_req = 1'b0;
        step(0, 0);
        i_req = 1'b1;
        repeat (15) step(0, 0);
        chk("stall_gap", stall_flag, 0);

        do_reset();
        t_req = 1'b1;
        repeat (16) step(0, 0);
        chk("side_cons", stall_side, 2'b10);
`else
        do_reset();
        step(1, 0);
        step(1, 0);
        i_req = 1'b1;
        repeat (40) step(0, 0);
        chk("no_mon", stall_flag, 0);
`endif
        do_reset();

        chk("rd_left", rd_exp.size(), 0);
        chk("wr_left", wr_exp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
